etroc1_readout: RTL and testbench
=================================

# etroc1_readout

Simplified ETROC1 pixel-matrix readout. Takes a 30-bit hit word from each pixel of a 4x4 array every bunch crossing, keeps a local BCID synchronised by `bc0`, and on each L1 accept snapshots the pixels selected by a 16-bit region-of-interest mask into an event FIFO. A scheduler serialises queued events onto one 30-bit output word per clock as header, hits, trailer, or idle. It sits between the pixel TDC/front-end array and the serializer/link.

## Interface
- `EVT_DEPTH`, 4: event FIFO depth in events (power of 2, ≥2).
- `clock` in 1: 40 MHz BX clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `l1acc` in 1: L1 accept, one-cycle pulse.
- `bc0` in 1: bunch-crossing-zero marker.
- `roi` in 16: pixel enable mask, bit index = row*4+col, sampled with `l1acc`.
- `din_R_C` (R,C ∈ 0..3, 16 ports) in 30: pixel words, {2'b00, row[3:0], col[3:0], payload[19:0]}.
- `dout` out 30: readout word stream.

## Operation
- Word types in `dout[29:28]`:
  - Data: {2'b00, din[27:0]}.
  - Header: {2'b01, evt_cnt[15:0], bcid[11:0]}.
  - Trailer: {2'b10, hit_cnt[4:0], ovf_cnt[7:0], 15'b0}.
  - Idle: 30'h3000_0000.
- BCID: 12-bit counter.
  - Cycle after `bc0`=1 it is 0; otherwise it increments, wrapping 4095→0.
- On `l1acc`=1 with FIFO not full, write one entry: all 16 `din`, `roi`, current `bcid`, `evt_cnt`.
  - `evt_cnt` (16-bit, wraps) increments on every `l1acc`, including dropped ones.
- On `l1acc` with FIFO full, drop the event and saturate-increment `ovf_cnt` (8-bit, stays at 255).
- Scheduler FSM:
  - IDLE: output Idle. If FIFO non-empty, pop into the working register, go to HDR.
  - HDR: output Header. Go to DATA, or to TRL if the popped `roi`=0.
  - DATA: output Data for each set `roi` bit, ascending index 0..15, one per cycle; zero bits are skipped with no gap. After the last set bit, go to TRL.
  - TRL: output Trailer with `hit_cnt` = popcount(`roi`). If FIFO non-empty, pop and go to HDR; else go to IDLE.
- Simultaneous `l1acc` write and scheduler pop are both honoured; fullness is evaluated before the pop.
- `l1acc` and `bc0` in the same cycle: the header carries the pre-reset BCID value.

## Timing
- `dout` is registered.
- Latency with FIFO empty and scheduler idle:
  - `l1acc` at cycle N: Header at N+2, first Data at N+3.
  - k hits: Trailer at N+3+k.
- Event occupies k+2 output cycles. Queued events follow back-to-back with no Idle between them.
- Reset (any time, including mid-event):
  - `dout` = Idle; FSM = IDLE; FIFO emptied; `bcid` = 0; `evt_cnt` = 0; `ovf_cnt` = 0.
  - An in-flight event is discarded without a trailer.

## Configuration
- `ETROC1_EMPTY_EVENT_EN`:
  - Defined: `roi`=0 events are queued and emitted as Header+Trailer with `hit_cnt`=0.
  - Undefined: `roi`=0 events are not written to the FIFO and produce no output. `evt_cnt` still increments.

## Structure
- Package `etroc1_pkg`:
  - word-type codes (DATA/HDR/TRL/IDLE);
  - `IDLE_WORD` constant;
  - pixel word width 30, `NPIX`=16;
  - event-entry struct typedef;
  - FSM state enum.
- Sub-module `etroc1_event_fifo`: synchronous FIFO of event entries, with full/empty flags.
- Top module: BCID counter, capture logic, scheduler FSM, priority encoder for the next set `roi` bit.

## Test plan
- Reset, no triggers → `dout`=30'h3000_0000 continuously; `bc0` every 3557 cycles → BCID returns to 0 the cycle after `bc0`.
- `l1acc` with `roi`=16'hFFFF → Header (evt_cnt 0, BCID at trigger), 16 Data words with row/col (0,0),(0,1)…(3,3) and identical payload, Trailer `hit_cnt`=16.
- `roi`=16'h8003 → Header, Data for R0C0, R0C1, R3C3, Trailer `hit_cnt`=3; 5 words total.
- `roi`=16'h000F → Header, Data for R0C0–R0C3, Trailer `hit_cnt`=4.
- `roi`=16'h0000 → with `ETROC1_EMPTY_EVENT_EN`: Header+Trailer with `hit_cnt`=0; without it: Idle only, and next header's `evt_cnt` still advances.
- Six `l1acc` on consecutive cycles with `roi`=16'hFFFF, `EVT_DEPTH`=4:
  - 5 events output back-to-back, 90 cycles;
  - 6th dropped;
  - trailers emitted after the drop show `ovf_cnt`=1;
  - mid-stream reset → Idle on the next cycle.

Source files
------------

// File: rtl/etroc1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | etroc1_pkg : shared types and constants for the ETROC1 readout       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package etroc1_pkg;

    localparam int PIX_W = 30;
    localparam int HIT_W = 28;
    localparam int NPIX  = 16;

    localparam logic [1:0] WT_DATA = 2'b00;
    localparam logic [1:0] WT_HDR  = 2'b01;
    localparam logic [1:0] WT_TRL  = 2'b10;
    localparam logic [1:0] WT_IDLE = 2'b11;

    localparam logic [PIX_W-1:0] IDLE_WORD = {WT_IDLE, {HIT_W{1'b0}}};

    typedef struct packed {
        logic [NPIX-1:0][HIT_W-1:0] hits;
        logic [NPIX-1:0]            roi;
        logic [11:0]                bcid;
        logic [15:0]                evt_cnt;
    } evt_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_TRL  = 2'd3
    } state_e;

    function automatic logic [4:0] popcount16(input logic [NPIX-1:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < NPIX; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/etroc1_readout_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | etroc1_readout_if : pixel inputs, trigger controls and output stream |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface etroc1_readout_if;
    import etroc1_pkg::*;

    logic             l1acc;
    logic             bc0;
    logic [NPIX-1:0]  roi;
    logic [PIX_W-1:0] din_0_0, din_0_1, din_0_2, din_0_3;
    logic [PIX_W-1:0] din_1_0, din_1_1, din_1_2, din_1_3;
    logic [PIX_W-1:0] din_2_0, din_2_1, din_2_2, din_2_3;
    logic [PIX_W-1:0] din_3_0, din_3_1, din_3_2, din_3_3;
    logic [PIX_W-1:0] dout;

    modport master (
        output l1acc, bc0, roi,
        output din_0_0, din_0_1, din_0_2, din_0_3,
        output din_1_0, din_1_1, din_1_2, din_1_3,
        output din_2_0, din_2_1, din_2_2, din_2_3,
        output din_3_0, din_3_1, din_3_2, din_3_3,
        input  dout
    );

    modport slave (
        input  l1acc, bc0, roi,
        input  din_0_0, din_0_1, din_0_2, din_0_3,
        input  din_1_0, din_1_1, din_1_2, din_1_3,
        input  din_2_0, din_2_1, din_2_2, din_2_3,
        input  din_3_0, din_3_1, din_3_2, din_3_3,
        output dout
    );
endinterface
`default_nettype wire

// File: rtl/etroc1_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | etroc1_event_fifo : first-word-fall-through FIFO of event snapshots  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module etroc1_event_fifo
    import etroc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       i_wr_en,
    input  wire evt_entry_t i_wr_data,
    input  wire logic       i_rd_en,
    output evt_entry_t      o_rd_data,
    output logic            o_full,
    output logic            o_empty
);
    localparam int AW = $clog2(DEPTH);

    evt_entry_t    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_wr;
    logic          w_do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;

    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/etroc1_readout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | etroc1_readout : 4x4 pixel L1 capture, event queue and word stream.  |
// | Option macro ETROC1_EMPTY_EVENT_EN emits roi=0 events as HDR+TRL.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module etroc1_readout
    import etroc1_pkg::*;
#(
    parameter int EVT_DEPTH = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    etroc1_readout_if.slave bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_HDR  = ST_HDR;
    localparam logic [1:0] S_DATA = ST_DATA;
    localparam logic [1:0] S_TRL  = ST_TRL;

    logic [NPIX-1:0][HIT_W-1:0] w_hits;
    logic                       w_unused_msb;

    assign w_hits[0]  = bus.din_0_0[HIT_W-1:0];
    assign w_hits[1]  = bus.din_0_1[HIT_W-1:0];
    assign w_hits[2]  = bus.din_0_2[HIT_W-1:0];
    assign w_hits[3]  = bus.din_0_3[HIT_W-1:0];
    assign w_hits[4]  = bus.din_1_0[HIT_W-1:0];
    assign w_hits[5]  = bus.din_1_1[HIT_W-1:0];
    assign w_hits[6]  = bus.din_1_2[HIT_W-1:0];
    assign w_hits[7]  = bus.din_1_3[HIT_W-1:0];
    assign w_hits[8]  = bus.din_2_0[HIT_W-1:0];
    assign w_hits[9]  = bus.din_2_1[HIT_W-1:0];
    assign w_hits[10] = bus.din_2_2[HIT_W-1:0];
    assign w_hits[11] = bus.din_2_3[HIT_W-1:0];
    assign w_hits[12] = bus.din_3_0[HIT_W-1:0];
    assign w_hits[13] = bus.din_3_1[HIT_W-1:0];
    assign w_hits[14] = bus.din_3_2[HIT_W-1:0];
    assign w_hits[15] = bus.din_3_3[HIT_W-1:0];

    // Pixel words carry a fixed 2'b00 prefix that the data word regenerates.
    assign w_unused_msb = ^{bus.din_0_0[PIX_W-1:HIT_W], bus.din_0_1[PIX_W-1:HIT_W],
                            bus.din_0_2[PIX_W-1:HIT_W], bus.din_0_3[PIX_W-1:HIT_W],
                            bus.din_1_0[PIX_W-1:HIT_W], bus.din_1_1[PIX_W-1:HIT_W],
                            bus.din_1_2[PIX_W-1:HIT_W], bus.din_1_3[PIX_W-1:HIT_W],
                            bus.din_2_0[PIX_W-1:HIT_W], bus.din_2_1[PIX_W-1:HIT_W],
                            bus.din_2_2[PIX_W-1:HIT_W], bus.din_2_3[PIX_W-1:HIT_W],
                            bus.din_3_0[PIX_W-1:HIT_W], bus.din_3_1[PIX_W-1:HIT_W],
                            bus.din_3_2[PIX_W-1:HIT_W], bus.din_3_3[PIX_W-1:HIT_W]};

    logic [11:0] r_bcid;
    logic [15:0] r_evt_cnt;
    logic [7:0]  r_ovf_cnt;

    always_ff @(posedge clock) begin
        if (reset || bus.bc0) begin
            r_bcid <= 12'd0;
        end else begin
            r_bcid <= r_bcid + 12'd1;
        end
    end

    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_evt_kept;
    logic       w_wr_en;
    logic       w_drop;
    evt_entry_t w_wr_data;
    evt_entry_t w_rd_data;

`ifdef ETROC1_EMPTY_EVENT_EN
    assign w_evt_kept = 1'b1;
`else
    assign w_evt_kept = |bus.roi;
`endif

    assign w_wr_en = bus.l1acc && !w_full && w_evt_kept;
    assign w_drop  = bus.l1acc && w_full;

    assign w_wr_data.hits    = w_hits;
    assign w_wr_data.roi     = bus.roi;
    assign w_wr_data.bcid    = r_bcid;
    assign w_wr_data.evt_cnt = r_evt_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_evt_cnt <= 16'd0;
            r_ovf_cnt <= 8'd0;
        end else begin
            if (bus.l1acc) r_evt_cnt <= r_evt_cnt + 16'd1;
            if (w_drop && (r_ovf_cnt != 8'hFF)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    etroc1_event_fifo #(
        .DEPTH     (EVT_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    logic [1:0]                 r_state;
    logic [PIX_W-1:0]           r_dout;
    logic [NPIX-1:0][HIT_W-1:0] r_work_hits;
    logic [NPIX-1:0]            r_mask;
    logic [4:0]                 r_hit_cnt;
    logic [3:0]                 w_idx;
    logic [1:0]                 w_state_nx;
    logic [PIX_W-1:0]           w_dout_nx;

    // Lowest still-pending roi bit selects the next data word.
    always_comb begin
        w_idx = 4'd0;
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (r_mask[i]) w_idx = 4'(i);
        end
    end

    // r_state names the word currently on dout; the next word is built
    // alongside the transition so that dout stays a plain register.
    always_comb begin
        w_pop      = 1'b0;
        w_state_nx = S_IDLE;
        w_dout_nx  = IDLE_WORD;
        case (r_state)
            S_IDLE, S_TRL: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_HDR;
                    w_dout_nx  = {WT_HDR, w_rd_data.evt_cnt, w_rd_data.bcid};
                end
            end
            S_HDR, S_DATA: begin
                if (r_mask == '0) begin
                    w_state_nx = S_TRL;
                    w_dout_nx  = {WT_TRL, r_hit_cnt, r_ovf_cnt, 15'd0};
                end else begin
                    w_state_nx = S_DATA;
                    w_dout_nx  = {WT_DATA, r_work_hits[w_idx]};
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_dout_nx  = IDLE_WORD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dout  <= IDLE_WORD;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dout  <= w_dout_nx;
            if (w_pop) begin
                r_mask <= w_rd_data.roi;
            end else if (w_state_nx == S_DATA) begin
                r_mask <= r_mask & ~(16'd1 << w_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_work_hits <= w_rd_data.hits;
            r_hit_cnt   <= popcount16(w_rd_data.roi);
        end
    end

    assign bus.dout = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_etroc1_readout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_etroc1_readout : directed checks of the ETROC1 readout stream     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_etroc1_readout;

    localparam logic [29:0] IDLE = 30'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_evt = 16'd0;
    logic [29:0] exp_q[$];

    etroc1_readout_if bus ();

    etroc1_readout #(
        .EVT_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [29:0] hdr_word(input logic [15:0] e, input logic [11:0] b);
        return {2'b01, e, b};
    endfunction

    function automatic logic [29:0] trl_word(input logic [4:0] h, input logic [7:0] o);
        return {2'b10, h, o, 15'd0};
    endfunction

    function automatic logic [29:0] data_word(input int idx, input logic [19:0] p);
        return {2'b00, 4'(idx / 4), 4'(idx % 4), p};
    endfunction

    task automatic push_event(input logic [15:0] e, input logic [11:0] b, input logic [15:0] roi,
                              input logic [19:0] p, input logic [4:0] hits, input logic [7:0] ovf);
        exp_q.push_back(hdr_word(e, b));
        for (int i = 0; i < 16; i++) begin
            if (roi[i]) exp_q.push_back(data_word(i, p));
        end
        exp_q.push_back(trl_word(hits, ovf));
    endtask

    task automatic set_din(input logic [19:0] p);
        bus.din_0_0 = {2'b00, 4'd0, 4'd0, p};
        bus.din_0_1 = {2'b00, 4'd0, 4'd1, p};
        bus.din_0_2 = {2'b00, 4'd0, 4'd2, p};
        bus.din_0_3 = {2'b00, 4'd0, 4'd3, p};
        bus.din_1_0 = {2'b00, 4'd1, 4'd0, p};
        bus.din_1_1 = {2'b00, 4'd1, 4'd1, p};
        bus.din_1_2 = {2'b00, 4'd1, 4'd2, p};
        bus.din_1_3 = {2'b00, 4'd1, 4'd3, p};
        bus.din_2_0 = {2'b00, 4'd2, 4'd0, p};
        bus.din_2_1 = {2'b00, 4'd2, 4'd1, p};
        bus.din_2_2 = {2'b00, 4'd2, 4'd2, p};
        bus.din_2_3 = {2'b00, 4'd2, 4'd3, p};
        bus.din_3_0 = {2'b00, 4'd3, 4'd0, p};
        bus.din_3_1 = {2'b00, 4'd3, 4'd1, p};
        bus.din_3_2 = {2'b00, 4'd3, 4'd2, p};
        bus.din_3_3 = {2'b00, 4'd3, 4'd3, p};
    endtask

    // bc0 for one cycle, then n quiet cycles: the next trigger sees bcid = n.
    task automatic sync_bc0(input int n);
        bus.bc0 = 1'b1;
        cyc();
        bus.bc0 = 1'b0;
        repeat (n) cyc();
    endtask

    // One-cycle l1acc; returns at the cycle where the header is due.
    task automatic fire(input logic [15:0] roi);
        bus.roi   = roi;
        bus.l1acc = 1'b1;
        cyc();
        bus.l1acc = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        bus.l1acc = 1'b0;
        bus.bc0   = 1'b0;
        bus.roi   = 16'h0000;
        set_din(20'h00000);
        reset = 1'b1;
        repeat (3) cyc();
        total++;
        if (bus.dout !== IDLE) begin
            bad++;
            $display("FAIL reset_hold: dout=%h expected=%h", bus.dout, IDLE);
        end
        reset = 1'b0;
        exp_evt = 16'd0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            total++;
            if (bus.dout !== IDLE) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: dout=%h expected=%h", i, bus.dout, IDLE);
            end
        end
    endtask

    task automatic test_roi(input logic [15:0] roi, input logic [19:0] p, input int bc,
                            input logic [4:0] hits);
        exp_q.delete();
        set_din(p);
        sync_bc0(bc);
        fire(roi);
        push_event(exp_evt, 12'(bc), roi, p, hits, 8'd0);
        exp_evt++;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL roi_%h word %0d: dout=%h expected=%h", roi, i, bus.dout, exp_q[i]);
            end
            cyc();
        end
    endtask

    task automatic test_empty_roi();
        exp_q.delete();
        sync_bc0(3);
        fire(16'h0000);
`ifdef ETROC1_EMPTY_EVENT_EN
        exp_q.push_back(hdr_word(exp_evt, 12'd3));
        exp_q.push_back(trl_word(5'd0, 8'd0));
`endif
        exp_evt++;
        repeat (4) exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL empty_roi word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
        exp_q.delete();
        set_din(20'h3C3C3);
        sync_bc0(4);
        fire(16'h0010);
        push_event(exp_evt, 12'd4, 16'h0010, 20'h3C3C3, 5'd1, 8'd0);
        exp_evt++;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL after_empty word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
    endtask

    task automatic test_bcid();
        exp_q.delete();
        set_din(20'h00C0A);
        bus.roi = 16'h0001;
        sync_bc0(3556);
        bus.bc0   = 1'b1;
        bus.l1acc = 1'b1;
        cyc();
        bus.bc0 = 1'b0;
        cyc();
        bus.l1acc = 1'b0;
        push_event(exp_evt, 12'd3556, 16'h0001, 20'h00C0A, 5'd1, 8'd0);
        exp_evt++;
        push_event(exp_evt, 12'd0, 16'h0001, 20'h00C0A, 5'd1, 8'd0);
        exp_evt++;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL bcid_bc0 word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
        exp_q.delete();
        set_din(20'h0F00D);
        sync_bc0(4097);
        fire(16'h0002);
        push_event(exp_evt, 12'd1, 16'h0002, 20'h0F00D, 5'd1, 8'd0);
        exp_evt++;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL bcid_wrap word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back_overflow();
        exp_q.delete();
        set_din(20'h5A5A5);
        bus.roi = 16'hFFFF;
        sync_bc0(0);
        bus.l1acc = 1'b1;
        cyc();
        cyc();
        for (int e = 0; e < 5; e++) begin
            push_event(exp_evt + 16'(e), 12'(e), 16'hFFFF, 20'h5A5A5, 5'd16, 8'd1);
        end
        exp_evt = exp_evt + 16'd6;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 4) bus.l1acc = 1'b0;
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL overflow word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
    endtask

    task automatic test_midstream_reset();
        set_din(20'h11111);
        fire(16'hFFFF);
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        total++;
        if (bus.dout !== IDLE) begin
            bad++;
            $display("FAIL midreset_first: dout=%h expected=%h", bus.dout, IDLE);
        end
        reset = 1'b0;
        exp_evt = 16'd0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (bus.dout !== IDLE) begin
                bad++;
                $display("FAIL midreset_idle cycle %0d: dout=%h expected=%h", i, bus.dout, IDLE);
            end
        end
        exp_q.delete();
        set_din(20'h77777);
        sync_bc0(6);
        fire(16'h0001);
        push_event(exp_evt, 12'd6, 16'h0001, 20'h77777, 5'd1, 8'd0);
        exp_evt++;
        exp_q.push_back(IDLE);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (bus.dout !== exp_q[i]) begin
                bad++;
                $display("FAIL post_reset word %0d: dout=%h expected=%h", i, bus.dout, exp_q[i]);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_roi(16'hFFFF, 20'hABCDE, 5, 5'd16);
        test_roi(16'h8003, 20'h12345, 7, 5'd3);
        test_roi(16'h000F, 20'hFEDCB, 2, 5'd4);
        test_empty_roi();
        test_bcid();
        test_back_to_back_overflow();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
